bram_heap_pq: RTL and testbench

- Parametrised successor to the single-BRAM heap queue.
- Implements a complete binary heap (min or max) in one true dual-port, read-first BRAM, with enqueue (sift-up), dequeue (last-to-root, then sift-down) and replace (root overwrite, then sift-down).
- Has an explicit ready handshake, occupancy output and a live top-of-heap register.
- Sits between a scheduler front-end and consumers that need the current best element every cycle.

---
 rtl/bram_heap_pq_if.sv | 27 ++
 rtl/bram_heap_pq.sv | 200 ++++++++++++++++++++
 tb/tb_bram_heap_pq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/bram_heap_pq_if.sv
// Command/status bundle of the BRAM heap priority queue.
// master drives commands (scheduler side); slave is the queue itself.
interface bram_heap_pq_if #(
  parameter int QUEUE_SIZE = 15,
  parameter int DATA_WIDTH = 16
);
  localparam int CW = $clog2(QUEUE_SIZE + 1);

  logic                  i_wrt;
  logic                  i_read;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_ready;
  logic                  o_full;
  logic                  o_empty;
  logic [CW-1:0]         o_count;
  logic [DATA_WIDTH-1:0] o_data;

  modport master (
    output i_wrt, i_read, i_data,
    input  o_ready, o_full, o_empty, o_count, o_data
  );

  modport slave (
    input  i_wrt, i_read, i_data,
    output o_ready, o_full, o_empty, o_count, o_data
  );
endinterface

// File: rtl/bram_heap_pq.sv
// Binary heap priority queue (min or max) kept in one true dual-port read-first BRAM.
// Supports enqueue (sift-up), dequeue (last-to-root + sift-down) and replace (root overwrite + sift-down).
module bram_heap_pq #(
  parameter int QUEUE_SIZE = 15,
  parameter int DATA_WIDTH = 16,
  parameter bit MAX_HEAP   = 1'b1
) (
  input logic           CLK,
  input logic           RSTn,
  bram_heap_pq_if.slave q
);
  localparam int AW = $clog2(QUEUE_SIZE);
  localparam int CW = $clog2(QUEUE_SIZE + 1);
  localparam int EW = AW + 2;

  typedef enum logic [3:0] {
    IDLE, UP_RD, UP_WAIT, UP_CMP, LAST_WAIT, LAST_WR, DN_RD, DN_WAIT, DN_CMP
  } state_t;

  state_t                state_reg, state_next;
  logic [AW-1:0]         idx_reg, idx_next;
  logic [DATA_WIDTH-1:0] node_reg, node_next;
  logic [CW-1:0]         count_reg, count_next;
  logic [DATA_WIDTH-1:0] top_reg, top_next;
  logic [AW-1:0]         addr_a_reg, addr_a_next, addr_b_reg, addr_b_next;
  logic [DATA_WIDTH-1:0] din_a_reg, din_a_next, din_b_reg, din_b_next;
  logic                  we_a_reg, we_a_next, we_b_reg, we_b_next;

  logic [DATA_WIDTH-1:0] mem [0:QUEUE_SIZE-1];
  logic [DATA_WIDTH-1:0] dout_a, dout_b;

  function automatic logic better(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (MAX_HEAP) return a > b;
    return a < b;
  endfunction

  // Both ports share one block so the array has a single driver; no reset keeps it a BRAM.
  always_ff @(posedge CLK) begin
    if (we_a_reg) mem[addr_a_reg] <= din_a_reg;
    if (we_b_reg) mem[addr_b_reg] <= din_b_reg;
    dout_a <= mem[addr_a_reg];
    dout_b <= mem[addr_b_reg];
  end

  logic [AW-1:0]         parent_idx;
  logic [EW-1:0]         left_ext, right_ext, count_ext;
  logic [CW-1:0]         count_m1;
  logic                  right_valid, pick_right;
  logic [DATA_WIDTH-1:0] child_val;
  logic [AW-1:0]         child_idx;
  logic                  is_full, is_empty;

  assign parent_idx  = (idx_reg - AW'(1)) >> 1;
  assign left_ext    = {1'b0, idx_reg, 1'b1};
  assign right_ext   = left_ext + EW'(1);
  assign count_ext   = EW'(count_reg);
  assign count_m1    = count_reg - CW'(1);
  assign right_valid = right_ext < count_ext;
  // Equal children keep the left one.
  assign pick_right  = right_valid && better(dout_b, dout_a);
  assign child_val   = pick_right ? dout_b : dout_a;
  assign child_idx   = pick_right ? right_ext[AW-1:0] : left_ext[AW-1:0];
  assign is_full     = count_reg == CW'(QUEUE_SIZE);
  assign is_empty    = count_reg == '0;

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    node_next   = node_reg;
    count_next  = count_reg;
    top_next    = top_reg;
    addr_a_next = addr_a_reg;
    addr_b_next = addr_b_reg;
    din_a_next  = din_a_reg;
    din_b_next  = din_b_reg;
    we_a_next   = 1'b0;
    we_b_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (q.i_wrt && q.i_read && !is_empty) begin
          we_a_next   = 1'b1;
          addr_a_next = '0;
          din_a_next  = q.i_data;
          node_next   = q.i_data;
          top_next    = q.i_data;
          idx_next    = '0;
          if (count_reg > CW'(1)) state_next = DN_RD;
        end else if (q.i_wrt) begin
          if (!is_full) begin
            we_a_next   = 1'b1;
            addr_a_next = count_reg[AW-1:0];
            din_a_next  = q.i_data;
            node_next   = q.i_data;
            idx_next    = count_reg[AW-1:0];
            count_next  = count_reg + CW'(1);
            if (is_empty) top_next = q.i_data;
            else          state_next = UP_RD;
          end
        end else if (q.i_read && !is_empty) begin
          count_next = count_m1;
          if (count_reg == CW'(1)) begin
            top_next = '0;
          end else begin
            addr_a_next = count_m1[AW-1:0];
            state_next  = LAST_WAIT;
          end
        end
      end
      UP_RD: begin
        addr_a_next = parent_idx;
        state_next  = UP_WAIT;
      end
      UP_WAIT: state_next = UP_CMP;
      UP_CMP: begin
        state_next = IDLE;
        if (better(node_reg, dout_a)) begin
          we_a_next   = 1'b1;
          addr_a_next = parent_idx;
          din_a_next  = node_reg;
          we_b_next   = 1'b1;
          addr_b_next = idx_reg;
          din_b_next  = dout_a;
          idx_next    = parent_idx;
          if (parent_idx == '0) top_next = node_reg;
          else                  state_next = UP_RD;
        end
      end
      LAST_WAIT: state_next = LAST_WR;
      LAST_WR: begin
        we_a_next   = 1'b1;
        addr_a_next = '0;
        din_a_next  = dout_a;
        node_next   = dout_a;
        top_next    = dout_a;
        idx_next    = '0;
        state_next  = DN_RD;
      end
      DN_RD: begin
        if (left_ext >= count_ext) begin
          state_next = IDLE;
        end else begin
          // A missing right child re-reads the left slot so port B never leaves the array.
          addr_a_next = left_ext[AW-1:0];
          addr_b_next = right_valid ? right_ext[AW-1:0] : left_ext[AW-1:0];
          state_next  = DN_WAIT;
        end
      end
      DN_WAIT: state_next = DN_CMP;
      DN_CMP: begin
        state_next = IDLE;
        if (better(child_val, node_reg)) begin
          we_a_next   = 1'b1;
          addr_a_next = idx_reg;
          din_a_next  = child_val;
          we_b_next   = 1'b1;
          addr_b_next = child_idx;
          din_b_next  = node_reg;
          idx_next    = child_idx;
          if (idx_reg == '0) top_next = child_val;
          state_next  = DN_RD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      node_reg   <= '0;
      count_reg  <= '0;
      top_reg    <= '0;
      addr_a_reg <= '0;
      addr_b_reg <= '0;
      din_a_reg  <= '0;
      din_b_reg  <= '0;
      we_a_reg   <= 1'b0;
      we_b_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      node_reg   <= node_next;
      count_reg  <= count_next;
      top_reg    <= top_next;
      addr_a_reg <= addr_a_next;
      addr_b_reg <= addr_b_next;
      din_a_reg  <= din_a_next;
      din_b_reg  <= din_b_next;
      we_a_reg   <= we_a_next;
      we_b_reg   <= we_b_next;
    end
  end

  assign q.o_ready = state_reg == IDLE;
  assign q.o_full  = is_full;
  assign q.o_empty = is_empty;
  assign q.o_count = count_reg;
  assign q.o_data  = top_reg;
endmodule

// File: tb/tb_bram_heap_pq.sv
// Bench for bram_heap_pq: a max-heap (7 x 16 bit) and a min-heap (5 x 8 bit) against
// an unordered-list model whose top is found by a linear scan.
module tb_bram_heap_pq;
  localparam int QA = 7;
  localparam int QB = 5;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   qa[$];
  int   qb[$];

  bram_heap_pq_if #(.QUEUE_SIZE(QA), .DATA_WIDTH(16)) ifa ();
  bram_heap_pq_if #(.QUEUE_SIZE(QB), .DATA_WIDTH(8))  ifb ();

  bram_heap_pq #(.QUEUE_SIZE(QA), .DATA_WIDTH(16), .MAX_HEAP(1'b1)) dut_max (
    .CLK(CLK), .RSTn(RSTn), .q(ifa)
  );
  bram_heap_pq #(.QUEUE_SIZE(QB), .DATA_WIDTH(8), .MAX_HEAP(1'b0)) dut_min (
    .CLK(CLK), .RSTn(RSTn), .q(ifb)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // which: 0 ready, 1 full, 2 empty, 3 count, 4 data
  function automatic int get_out(input int sel, input int which);
    if (sel == 0) begin
      case (which)
        0: return int'(ifa.o_ready);
        1: return int'(ifa.o_full);
        2: return int'(ifa.o_empty);
        3: return int'(ifa.o_count);
        default: return int'(ifa.o_data);
      endcase
    end
    case (which)
      0: return int'(ifb.o_ready);
      1: return int'(ifb.o_full);
      2: return int'(ifb.o_empty);
      3: return int'(ifb.o_count);
      default: return int'(ifb.o_data);
    endcase
  endfunction

  task automatic drive(input int sel, input logic w, input logic r, input int d);
    if (sel == 0) begin
      ifa.i_wrt = w; ifa.i_read = r; ifa.i_data = 16'(d);
    end else begin
      ifb.i_wrt = w; ifb.i_read = r; ifb.i_data = 8'(d);
    end
  endtask

  // Position of the best element (largest for sel 0, smallest for sel 1), -1 if none.
  function automatic int best_pos(input int sel, input int m[$]);
    int p;
    p = -1;
    for (int i = 0; i < m.size(); i++)
      if (p < 0 || (sel == 0 ? m[i] > m[p] : m[i] < m[p])) p = i;
    return p;
  endfunction

  // Called at a falling edge with o_ready high; returns at a falling edge with o_ready high.
  task automatic op(input int sel, input bit w, input bit r, input int d_in, input string tag);
    int m[$];
    int cap, d, cnt, lat, bound, exp_lat, p, exp_top;
    if (sel == 0) begin m = qa; cap = QA; d = d_in & 16'hFFFF; end
    else          begin m = qb; cap = QB; d = d_in & 8'hFF;    end
    cnt     = m.size();
    exp_lat = 1;
    bound   = 1;
    if (w && r && cnt > 0) begin
      m.delete(best_pos(sel, m));
      m.push_back(d);
      if (cnt > 1) begin exp_lat = -1; bound = 8; end
    end else if (w) begin
      if (cnt < cap) begin
        m.push_back(d);
        if (cnt > 0) begin exp_lat = -1; bound = 7; end
      end
    end else if (r && cnt > 0) begin
      m.delete(best_pos(sel, m));
      if (cnt > 1) begin exp_lat = -1; bound = 10; end
    end

    drive(sel, w, r, d);
    @(negedge CLK);
    drive(sel, 1'b0, 1'b0, 0);
    lat = 1;
    while (get_out(sel, 0) == 0 && lat < 60) begin
      @(negedge CLK);
      lat++;
    end
    p       = best_pos(sel, m);
    exp_top = (p < 0) ? 0 : m[p];
    check({tag, "_ready"}, get_out(sel, 0), 1);
    if (exp_lat > 0) check({tag, "_lat"}, lat, exp_lat);
    else             check({tag, "_lat_bound"}, int'(lat <= bound), 1);
    check({tag, "_count"}, get_out(sel, 3), m.size());
    check({tag, "_top"},   get_out(sel, 4), exp_top);
    check({tag, "_full"},  get_out(sel, 1), int'(m.size() == cap));
    check({tag, "_empty"}, get_out(sel, 2), int'(m.size() == 0));
    if (sel == 0) qa = m; else qb = m;
    $display("txn %s sel=%0d w=%0d r=%0d d=%0d top=%0d count=%0d lat=%0d",
             tag, sel, w, r, d, get_out(sel, 4), get_out(sel, 3), lat);
  endtask

  task automatic check_reset_state(input string tag);
    for (int s = 0; s < 2; s++) begin
      check({tag, "_ready"}, get_out(s, 0), 1);
      check({tag, "_full"},  get_out(s, 1), 0);
      check({tag, "_empty"}, get_out(s, 2), 1);
      check({tag, "_count"}, get_out(s, 3), 0);
      check({tag, "_data"},  get_out(s, 4), 0);
    end
  endtask

  initial begin
    int sel, kind, v;
    int vals_min[5];
    drive(0, 1'b0, 1'b0, 0);
    drive(1, 1'b0, 1'b0, 0);
    repeat (2) @(negedge CLK);
    check_reset_state("reset");
    RSTn = 1'b1;
    @(negedge CLK);

    // Enqueue order into the max heap
    op(0, 1, 0, 5,  "enq5");
    op(0, 1, 0, 9,  "enq9");
    op(0, 1, 0, 3,  "enq3");
    op(0, 1, 0, 12, "enq12");
    // Replace the root, then drain
    op(0, 1, 1, 4, "repl4");
    for (int i = 0; i < 4; i++) op(0, 0, 1, 0, "deq_after_repl");
    // Empty corner cases
    op(0, 0, 1, 0,  "deq_empty");
    op(0, 1, 1, 10, "repl_empty");
    op(0, 0, 1, 0,  "deq_single");
    // Fill, overflow attempt, drain
    for (int i = 1; i <= 7; i++) op(0, 1, 0, i, "fill");
    op(0, 1, 0, 8, "enq_full");
    for (int i = 0; i < 7; i++) op(0, 0, 1, 0, "drain");

    // Min heap with duplicates and extremes
    vals_min = '{200, 17, 17, 255, 0};
    for (int i = 0; i < 5; i++) op(1, 1, 0, vals_min[i], "min_enq");
    for (int i = 0; i < 5; i++) op(1, 0, 1, 0, "min_deq");

    // Reset in the middle of a sift-down
    for (int i = 1; i <= 7; i++) op(0, 1, 0, i, "refill");
    for (int i = 0; i < 3; i++) op(0, 0, 1, 0, "pre_rst_deq");
    drive(0, 1'b0, 1'b1, 0);
    @(negedge CLK);
    drive(0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge CLK);
    #2 RSTn = 1'b0;
    #1 check_reset_state("mid_reset");
    qa.delete();
    qb.delete();
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    op(0, 1, 0, 4, "post_rst_enq");

    // Random mix on both heaps; small value range forces ties
    for (int i = 0; i < 250; i++) begin
      sel  = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 3));
      v    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
      case (kind)
        0, 1: op(sel, 1, 0, v, "rnd_enq");
        2:    op(sel, 0, 1, v, "rnd_deq");
        default: op(sel, 1, 1, v, "rnd_repl");
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
